// File: rtl/mips_multicycle_ctrl.sv
// ============================================================================
// Module      : mips_multicycle_ctrl
// Description : Moore main controller and ALU decoder for a multicycle MIPS32
//               datapath. Optional ori support is enabled by MC_CTRL_ORI_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               zeroFlag,
  output logic               pcEn,
  output logic               irWrite,
  output logic               memWrite,
  output logic               regWrite,
  output logic               iOrD,
  output logic               memToReg,
  output logic               regDst,
  output logic               aluSrcA,
  output logic [1:0]         aluSrcB,
  output logic [1:0]         pcSrc,
  output logic               immZeroExt,
  output logic [2:0]         aluControl,
  output logic               illegalOp,
  output logic [STATE_W-1:0] stateOut
);

  localparam logic [5:0] C_OP_RTYPE = 6'b000000;
  localparam logic [5:0] C_OP_J     = 6'b000010;
  localparam logic [5:0] C_OP_BEQ   = 6'b000100;
  localparam logic [5:0] C_OP_ADDI  = 6'b001000;
`ifdef MC_CTRL_ORI_EN
  localparam logic [5:0] C_OP_ORI   = 6'b001101;
`endif
  localparam logic [5:0] C_OP_LW    = 6'b100011;
  localparam logic [5:0] C_OP_SW    = 6'b101011;

  localparam logic [1:0] C_ALUOP_ADD   = 2'b00;
  localparam logic [1:0] C_ALUOP_SUB   = 2'b01;
  localparam logic [1:0] C_ALUOP_FUNCT = 2'b10;
`ifdef MC_CTRL_ORI_EN
  localparam logic [1:0] C_ALUOP_OR    = 2'b11;
`endif

  typedef enum logic [STATE_W-1:0] {
    FETCH  = 0,
    DECODE = 1,
    MEMADR = 2,
    MEMRD  = 3,
    MEMWB  = 4,
    MEMWR  = 5,
    EXEC   = 6,
    ALUWB  = 7,
    BRANCH = 8,
    ADDIEX = 9,
    ADDIWB = 10,
    JUMP   = 11,
    ORIEX  = 12
  } state_t;

  typedef struct packed {
    logic       pcWrite;
    logic       branch;
    logic       irWrite;
    logic       memWrite;
    logic       regWrite;
    logic       iOrD;
    logic       memToReg;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic [1:0] aluOp;
  } ctl_t;

  state_t state_q;
  state_t state_d;
  ctl_t   ctl_q;
  logic   w_op_unsupported;

  // Control word for the state being entered; registered so outputs are glitch-free.
  function automatic ctl_t ctl_of(input state_t s);
    ctl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.irWrite = 1'b1;
        c.pcWrite = 1'b1;
        c.aluSrcB = 2'b01;
        c.aluOp   = C_ALUOP_ADD;
      end
      DECODE: begin
        c.aluSrcB = 2'b11;
        c.aluOp   = C_ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp   = C_ALUOP_ADD;
      end
      MEMRD: c.iOrD = 1'b1;
      MEMWB: begin
        c.memToReg = 1'b1;
        c.regWrite = 1'b1;
      end
      MEMWR: begin
        c.iOrD     = 1'b1;
        c.memWrite = 1'b1;
      end
      EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b00;
        c.aluOp   = C_ALUOP_FUNCT;
      end
      ALUWB: begin
        c.regDst   = 1'b1;
        c.regWrite = 1'b1;
      end
      ADDIWB: c.regWrite = 1'b1;
      BRANCH: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = C_ALUOP_SUB;
        c.pcSrc   = 2'b01;
        c.branch  = 1'b1;
      end
      JUMP: begin
        c.pcSrc   = 2'b10;
        c.pcWrite = 1'b1;
      end
`ifdef MC_CTRL_ORI_EN
      ORIEX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'b10;
        c.aluOp   = C_ALUOP_OR;
      end
`endif
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d          = FETCH;
    w_op_unsupported = 1'b0;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (opcode)
          C_OP_LW, C_OP_SW: state_d = MEMADR;
          C_OP_RTYPE:       state_d = EXEC;
          C_OP_BEQ:         state_d = BRANCH;
          C_OP_ADDI:        state_d = ADDIEX;
          C_OP_J:           state_d = JUMP;
`ifdef MC_CTRL_ORI_EN
          C_OP_ORI:         state_d = ORIEX;
`endif
          default:          w_op_unsupported = 1'b1;
        endcase
      end
      MEMADR: state_d = (opcode == C_OP_LW) ? MEMRD : MEMWR;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
`ifdef MC_CTRL_ORI_EN
      ORIEX:  state_d = ADDIWB;
`endif
      default: state_d = FETCH;
    endcase
  end

`ifdef MC_CTRL_ORI_EN
  logic immZeroExt_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      ctl_q   <= ctl_of(FETCH);
`ifdef MC_CTRL_ORI_EN
      immZeroExt_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ctl_q   <= ctl_of(state_d);
`ifdef MC_CTRL_ORI_EN
      immZeroExt_q <= (state_d == ORIEX);
`endif
    end
  end

`ifdef MC_CTRL_ORI_EN
  assign immZeroExt = immZeroExt_q;
`else
  assign immZeroExt = 1'b0;
`endif

  // Write enables are gated by reset so nothing commits while it is held.
  assign pcEn      = ~reset & (ctl_q.pcWrite | (ctl_q.branch & zeroFlag));
  assign irWrite   = ~reset & ctl_q.irWrite;
  assign memWrite  = ~reset & ctl_q.memWrite;
  assign regWrite  = ~reset & ctl_q.regWrite;
  assign illegalOp = ~reset & w_op_unsupported;
  assign iOrD      = ctl_q.iOrD;
  assign memToReg  = ctl_q.memToReg;
  assign regDst    = ctl_q.regDst;
  assign aluSrcA   = ctl_q.aluSrcA;
  assign aluSrcB   = ctl_q.aluSrcB;
  assign pcSrc     = ctl_q.pcSrc;
  assign stateOut  = state_q;

  always_comb begin
    aluControl = 3'b010;
    case (ctl_q.aluOp)
      2'b00: aluControl = 3'b010;
      2'b01: aluControl = 3'b110;
      2'b11: aluControl = 3'b001;
      default: begin
        case (funct)
          6'b100000: aluControl = 3'b010;
          6'b100010: aluControl = 3'b110;
          6'b100100: aluControl = 3'b000;
          6'b100101: aluControl = 3'b001;
          6'b101010: aluControl = 3'b111;
          default:   aluControl = 3'b010;
        endcase
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
// ============================================================================
// Module      : tb_mips_multicycle_ctrl
// Description : Randomized self-checking bench for mips_multicycle_ctrl against
//               an instruction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_multicycle_ctrl;

`ifdef MC_CTRL_ORI_EN
  localparam bit C_ORI_EN = 1'b1;
`else
  localparam bit C_ORI_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zeroFlag;
  logic        pcEn, irWrite, memWrite, regWrite, iOrD, memToReg, regDst, aluSrcA;
  logic [1:0]  aluSrcB, pcSrc;
  logic        immZeroExt, illegalOp;
  logic [2:0]  aluControl;
  logic [3:0]  stateOut;
  logic [16:0] w_outs;

  int n_cmp = 0;
  int n_err = 0;
  int zf_force = -1;

  mips_multicycle_ctrl #(.STATE_W(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zeroFlag(zeroFlag),
    .pcEn(pcEn), .irWrite(irWrite), .memWrite(memWrite), .regWrite(regWrite),
    .iOrD(iOrD), .memToReg(memToReg), .regDst(regDst), .aluSrcA(aluSrcA),
    .aluSrcB(aluSrcB), .pcSrc(pcSrc), .immZeroExt(immZeroExt),
    .aluControl(aluControl), .illegalOp(illegalOp), .stateOut(stateOut)
  );

  assign w_outs = {pcEn, irWrite, memWrite, regWrite, iOrD, memToReg, regDst, aluSrcA,
                   aluSrcB, pcSrc, immZeroExt, aluControl, illegalOp};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: instruction-centric view of cycle count, state and outputs.
  function automatic int exp_len(input logic [5:0] op);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b000000, 6'b001000: return 4;
      6'b000100, 6'b000010: return 3;
      6'b001101: return C_ORI_EN ? 4 : 2;
      default: return 2;
    endcase
  endfunction

  function automatic logic [3:0] exp_state(input logic [5:0] op, input int k);
    if (k == 0) return 4'd0;
    if (k == 1) return 4'd1;
    case (op)
      6'b100011: return (k == 2) ? 4'd2 : (k == 3) ? 4'd3 : 4'd4;
      6'b101011: return (k == 2) ? 4'd2 : 4'd5;
      6'b000000: return (k == 2) ? 4'd6 : 4'd7;
      6'b001000: return (k == 2) ? 4'd9 : 4'd10;
      6'b000100: return 4'd8;
      6'b000010: return 4'd11;
      6'b001101: return (k == 2) ? 4'd12 : 4'd10;
      default:   return 4'hf;
    endcase
  endfunction

  function automatic logic [2:0] alu_for_funct(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic logic [16:0] exp_outs(input logic [5:0] op, input logic [5:0] fn,
                                           input int k, input logic zf);
    logic pe, irw, mw, rw, iod, m2r, rd, sa, iz, il;
    logic [1:0] sb, ps;
    logic [2:0] ac;
    {pe, irw, mw, rw, iod, m2r, rd, sa, iz, il} = '0;
    sb = 2'b00; ps = 2'b00; ac = 3'b010;
    if (k == 0) begin
      irw = 1'b1; pe = 1'b1; sb = 2'b01;
    end else if (k == 1) begin
      sb = 2'b11; il = (exp_len(op) == 2);
    end else begin
      case (op)
        6'b100011, 6'b101011, 6'b001000: begin
          if (k == 2) begin sa = 1'b1; sb = 2'b10; end
          else if (op == 6'b101011) begin iod = 1'b1; mw = 1'b1; end
          else if (op == 6'b001000) rw = 1'b1;
          else if (k == 3) iod = 1'b1;
          else begin m2r = 1'b1; rw = 1'b1; end
        end
        6'b000000: begin
          if (k == 2) begin sa = 1'b1; ac = alu_for_funct(fn); end
          else begin rd = 1'b1; rw = 1'b1; end
        end
        6'b000100: begin sa = 1'b1; ac = 3'b110; ps = 2'b01; pe = zf; end
        6'b000010: begin ps = 2'b10; pe = 1'b1; end
        6'b001101: begin
          if (k == 2) begin sa = 1'b1; sb = 2'b10; ac = 3'b001; iz = 1'b1; end
          else rw = 1'b1;
        end
        default: ;
      endcase
    end
    return {pe, irw, mw, rw, iod, m2r, rd, sa, sb, ps, iz, ac, il};
  endfunction

  function automatic logic [16:0] rst_outs();
    return {8'b0, 2'b01, 2'b00, 1'b0, 3'b010, 1'b0};
  endfunction

  // Called just after a rising edge with the DUT in FETCH.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int abort_at);
    opcode = op;
    funct  = fn;
    for (int k = 0; k < exp_len(op); k++) begin
      zeroFlag = (zf_force < 0) ? 1'($urandom_range(0, 1)) : 1'(zf_force);
      @(negedge clk);
      check($sformatf("state op=%b k=%0d", op, k), 32'(stateOut), 32'(exp_state(op, k)));
      check($sformatf("outs op=%b fn=%b k=%0d", op, fn, k), 32'(w_outs),
            32'(exp_outs(op, fn, k, zeroFlag)));
      if (k == abort_at) begin
        reset = 1'b1;
        #1;
        check("async_rst_state", 32'(stateOut), 32'd0);
        check("async_rst_outs", 32'(w_outs), 32'(rst_outs()));
        @(posedge clk); #1;
        check("held_rst_state", 32'(stateOut), 32'd0);
        check("held_rst_outs", 32'(w_outs), 32'(rst_outs()));
        reset = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  logic [5:0] op_tbl [10];
  logic [5:0] fn_tbl [7];

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; zeroFlag = 1'b0;
    op_tbl = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
               6'b001000, 6'b000010, 6'b001101, 6'b111111, 6'b000000};
    fn_tbl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111, 6'b000000};
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 32'(stateOut), 32'd0);
    check("rst_outs", 32'(w_outs), 32'(rst_outs()));
    reset = 1'b0;

    run_instr(6'b100011, 6'b000000, -1);
    run_instr(6'b000000, 6'b101010, -1);
    run_instr(6'b000000, 6'b100100, -1);
    run_instr(6'b000000, 6'b111111, -1);
    zf_force = 1; run_instr(6'b000100, 6'b000000, -1);
    zf_force = 0; run_instr(6'b000100, 6'b000000, -1);
    zf_force = -1;
    run_instr(6'b000010, 6'b000000, -1);
    run_instr(6'b111111, 6'b000000, -1);
    run_instr(6'b001101, 6'b000000, -1);
    run_instr(6'b101011, 6'b000000, 3);
    run_instr(6'b101011, 6'b000000, -1);

    for (int i = 0; i < 300; i++) begin
      logic [5:0] op;
      logic [5:0] fn;
      op = op_tbl[$urandom_range(0, 9)];
      if (op == 6'b000000 && $urandom_range(0, 3) == 0) op = 6'($urandom);
      fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fn_tbl[$urandom_range(0, 6)];
      run_instr(op, fn, ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, exp_len(op) - 1)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main controller plus ALU decoder for the multicycle MIPS32 datapath.
- Sits directly upstream of the ALU. Drives its 3-bit aluControl and the operand/writeback muxes and write enables around it.
- Consumes the ALU zeroFlag to resolve beq.
- Instruction execution lengths: 3 cycles (beq, j), 4 cycles (R-type, addi, sw), 5 cycles (lw).

Parameters:
- STATE_W, 4, width of state register and of the stateOut debug port.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from instruction register
- funct  input  6  instr[5:0] from instruction register
- zeroFlag  input  1  ALU zero flag
- pcEn  output  1  PC register enable
- irWrite  output  1  instruction register load
- memWrite  output  1  data memory write
- regWrite  output  1  register file write
- iOrD  output  1  memory address: 0 = PC, 1 = ALUOut
- memToReg  output  1  writeback: 0 = ALUOut, 1 = MDR
- regDst  output  1  destination register: 0 = rt, 1 = rd
- aluSrcA  output  1  0 = PC, 1 = regA
- aluSrcB  output  2  00 = regB, 01 = const 4, 10 = signext imm, 11 = signext imm<<2
- pcSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- immZeroExt  output  1  selects zero-extension of imm on the srcB 10 path
- aluControl  output  3  ALU operation select
- illegalOp  output  1  unsupported opcode seen in DECODE
- stateOut  output  STATE_W  current state (debug)

Behaviour:
- Clock, reset and state register:
  - One clock: clk.
  - reset is asynchronous, active-high. Asserting it forces state = FETCH immediately.
  - While reset is high, pcEn, irWrite, memWrite, regWrite and illegalOp are forced to 0. Other outputs take their FETCH values.
  - The first fetch occurs on the first rising edge after reset deasserts.
  - Reset asserted mid-instruction abandons the instruction. No further write enables assert until after reset deasserts.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, ORIEX=12. Values 13–15 return to FETCH on the next edge.
- Transitions:
  - FETCH -> DECODE.
  - DECODE, by opcode: lw 100011 / sw 101011 -> MEMADR; R-type 000000 -> EXEC; beq 000100 -> BRANCH; addi 001000 -> ADDIEX; j 000010 -> JUMP; any other -> FETCH.
  - MEMADR -> MEMRD if lw, else MEMWR.
  - MEMRD -> MEMWB.
  - EXEC -> ALUWB.
  - ADDIEX -> ADDIWB.
  - MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
- Outputs are a function of state only, except aluControl and pcEn. Every signal not listed for a state is 0.
  - FETCH: irWrite=1, pcWrite=1, aluSrcB=01, aluOp=00.
  - DECODE: aluSrcB=11, aluOp=00 (branch target to ALUOut).
  - MEMADR, ADDIEX: aluSrcA=1, aluSrcB=10, aluOp=00.
  - MEMRD: iOrD=1.
  - MEMWB: memToReg=1, regWrite=1.
  - MEMWR: iOrD=1, memWrite=1.
  - EXEC: aluSrcA=1, aluSrcB=00, aluOp=10.
  - ALUWB: regDst=1, regWrite=1.
  - ADDIWB: regWrite=1.
  - BRANCH: aluSrcA=1, aluOp=01, pcSrc=01, branch=1.
  - JUMP: pcSrc=10, pcWrite=1.
- illegalOp is 1 for exactly the DECODE cycle of an unsupported opcode. The instruction is otherwise treated as a NOP.
- pcEn = pcWrite | (branch & zeroFlag). This is combinational, so zeroFlag is sampled in the BRANCH cycle.
- ALU decoder (combinational):
  - aluOp 00 -> 010 (add).
  - aluOp 01 -> 110 (sub).
  - aluOp 11 -> 001 (or).
  - aluOp 10 decodes funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111; any other funct -> 010.

Optional Feature:
- Macro: MC_CTRL_ORI_EN.
- Defined:
  - DECODE with opcode 001101 -> ORIEX.
  - ORIEX: aluSrcA=1, aluSrcB=10, aluOp=11, immZeroExt=1.
  - ORIEX -> ADDIWB.
- Undefined:
  - opcode 001101 is illegal (illegalOp pulse, return to FETCH).
  - ORIEX is unreachable; immZeroExt is tied to 0.

Test Plan:
- Reset: assert reset mid-MEMWR -> memWrite drops to 0 asynchronously and stateOut=0. After deassert, the first edge gives stateOut=1.
- lw (opcode 100011): stateOut sequence 0,1,2,3,4,0. iOrD=1 in MEMRD. regWrite=1 and memToReg=1 only in MEMWB.
- R-type slt (opcode 000000, funct 101010): EXEC gives aluControl=111 and aluSrcA=1. ALUWB gives regDst=1 and regWrite=1. funct 100100 gives aluControl=000; funct 111111 gives 010.
- beq (000100): in BRANCH, zeroFlag=1 -> pcEn=1 and pcSrc=01; zeroFlag=0 -> pcEn=0. Both cases next state FETCH.
- j (000010) -> pcEn=1 and pcSrc=10 in JUMP. Opcode 111111 -> illegalOp=1 for one cycle, then FETCH, with no regWrite or memWrite.
- ori (001101):
  - With MC_CTRL_ORI_EN: state sequence 0,1,12,10,0; ORIEX gives aluControl=001 and immZeroExt=1.
  - Without it: illegalOp=1 and immZeroExt stays 0.
